// File: rtl/cnn_weight_pack_buffer_if.sv
// Load/write/read bus of the CNN weight pack buffer.
// The master is the weight loader and PE side; the slave is the buffer.
interface cnn_weight_pack_buffer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 6
);
    logic                     load_start;
    logic [ADDR_W:0]          load_words;
    logic                     load_flush;
    logic                     wr_valid;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ready;
    logic                     load_done;
    logic [ADDR_W:0]          words_loaded;
    logic                     err;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr1;
    logic [ADDR_W-1:0]        rd_addr2;
    logic [ADDR_W-1:0]        rd_offset;
    logic [LANES*DATA_W-1:0]  rd_data1;
    logic [LANES*DATA_W-1:0]  rd_data2;
    logic                     rd_valid;

    modport master (
        output load_start, load_words, load_flush, wr_valid, wr_data,
        output rd_en, rd_addr1, rd_addr2, rd_offset,
        input  wr_ready, load_done, words_loaded, err,
        input  rd_data1, rd_data2, rd_valid
    );

    modport slave (
        input  load_start, load_words, load_flush, wr_valid, wr_data,
        input  rd_en, rd_addr1, rd_addr2, rd_offset,
        output wr_ready, load_done, words_loaded, err,
        output rd_data1, rd_data2, rd_valid
    );
endinterface

// File: rtl/cnn_weight_pack_buffer.sv
// Packs a serial weight stream LANES-at-a-time into a DEPTH-word buffer
// and serves two registered read ports (port 2 offset by a runtime base).
module cnn_weight_pack_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input logic                     clk,
    input logic                     rst,
    cnn_weight_pack_buffer_if.slave bus
);
    localparam int unsigned WORD_W = LANES * DATA_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [LANES-1:0][DATA_W-1:0] pack_t;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    load_words_q, load_words_d;
    logic [CNT_W-1:0]    words_loaded_q, words_loaded_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    pack_t               pack_q, pack_d;
    logic                load_done_q, load_done_d;
    logic                err_q, err_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]   rd_data1_q, rd_data1_d;
    logic [WORD_W-1:0]   rd_data2_q, rd_data2_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;

    logic                start_ok;
    logic                wr_ready_c;
    logic                accept;
    pack_t               pack_next;
    logic [CNT_W-1:0]    rd_addr2_sum;

    // Load control: FSM, lane packing and word commit.
    always_comb begin
        state_d        = state_q;
        load_words_d   = load_words_q;
        words_loaded_d = words_loaded_q;
        lane_cnt_d     = lane_cnt_q;
        pack_d         = pack_q;
        load_done_d    = load_done_q;
        err_d          = err_q;
        mem_we         = 1'b0;
        mem_waddr      = words_loaded_q[ADDR_W-1:0];
        mem_wdata      = '0;

        start_ok   = bus.load_start && (bus.load_words != '0)
                     && (bus.load_words <= CNT_W'(DEPTH));
        wr_ready_c = (state_q == LOAD) && !bus.load_start && !bus.load_flush;
        accept     = bus.wr_valid && wr_ready_c;

        pack_next             = pack_q;
        pack_next[lane_cnt_q] = bus.wr_data;

        // A weight coinciding with a load control pulse is dropped silently.
        if (bus.wr_valid && (state_q != LOAD) && !bus.load_start && !bus.load_flush) begin
            err_d = 1'b1;
        end

        if (bus.load_start) begin
            if (start_ok) begin
                state_d        = LOAD;
                load_words_d   = bus.load_words;
                words_loaded_d = '0;
                lane_cnt_d     = '0;
                pack_d         = '0;
                load_done_d    = 1'b0;
                err_d          = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if ((state_q == LOAD) && bus.load_flush) begin
            if (lane_cnt_q != '0) begin
                mem_we         = 1'b1;
                mem_wdata      = pack_q;
                words_loaded_d = words_loaded_q + 1'b1;
            end
            lane_cnt_d  = '0;
            pack_d      = '0;
            state_d     = DONE;
            load_done_d = 1'b1;
        end else if (accept) begin
            if (lane_cnt_q == LANE_W'(LANES - 1)) begin
                mem_we         = 1'b1;
                mem_wdata      = pack_next;
                words_loaded_d = words_loaded_q + 1'b1;
                lane_cnt_d     = '0;
                pack_d         = '0;
                if (words_loaded_d == load_words_q) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                end
            end else begin
                lane_cnt_d = lane_cnt_q + 1'b1;
                pack_d     = pack_next;
            end
        end
    end

    // Read ports: out-of-range addresses return zero; data holds when idle.
    always_comb begin
        rd_valid_d   = bus.rd_en;
        rd_data1_d   = rd_data1_q;
        rd_data2_d   = rd_data2_q;
        rd_addr2_sum = CNT_W'(bus.rd_addr2) + CNT_W'(bus.rd_offset);
        if (bus.rd_en) begin
            rd_data1_d = (CNT_W'(bus.rd_addr1) < CNT_W'(DEPTH)) ? mem_q[bus.rd_addr1] : '0;
            rd_data2_d = (rd_addr2_sum < CNT_W'(DEPTH))
                         ? mem_q[rd_addr2_sum[ADDR_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            load_words_q   <= '0;
            words_loaded_q <= '0;
            lane_cnt_q     <= '0;
            pack_q         <= '0;
            load_done_q    <= 1'b0;
            err_q          <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data1_q     <= '0;
            rd_data2_q     <= '0;
        end else begin
            state_q        <= state_d;
            load_words_q   <= load_words_d;
            words_loaded_q <= words_loaded_d;
            lane_cnt_q     <= lane_cnt_d;
            pack_q         <= pack_d;
            load_done_q    <= load_done_d;
            err_q          <= err_d;
            rd_valid_q     <= rd_valid_d;
            rd_data1_q     <= rd_data1_d;
            rd_data2_q     <= rd_data2_d;
        end
    end

    // Weight storage is not reset; reads see the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.wr_ready     = wr_ready_c;
    assign bus.load_done    = load_done_q;
    assign bus.words_loaded = words_loaded_q;
    assign bus.err          = err_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data1     = rd_data1_q;
    assign bus.rd_data2     = rd_data2_q;
endmodule

// File: tb/tb_cnn_weight_pack_buffer.sv
// Bench for cnn_weight_pack_buffer: directed load/read scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_cnn_weight_pack_buffer;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned WORD_W = LANES * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_weight_pack_buffer_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    cnn_weight_pack_buffer #(
        .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [WORD_W-1:0] got,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: load status, pending weights and known memory image.
    bit                m_loading, m_done, m_err;
    int                m_target, m_count;
    logic [DATA_W-1:0] m_lanes[$];
    logic [WORD_W-1:0] m_mem [DEPTH];
    bit                m_memk [DEPTH];
    logic [WORD_W-1:0] e_rd1, e_rd2;
    bit                e_rd1k, e_rd2k, e_rdv;

    function automatic void m_reset();
        m_loading = 0; m_done = 0; m_err = 0; m_count = 0; m_target = 0;
        m_lanes.delete();
        e_rd1 = '0; e_rd2 = '0; e_rd1k = 1; e_rd2k = 1; e_rdv = 0;
    endfunction

    function automatic void m_commit();
        logic [WORD_W-1:0] w;
        w = '0;
        foreach (m_lanes[k]) w[k*DATA_W +: DATA_W] = m_lanes[k];
        m_mem[m_count]  = w;
        m_memk[m_count] = 1;
        m_count++;
        m_lanes.delete();
    endfunction

    function automatic void m_read(input int addr, output logic [WORD_W-1:0] w, output bit known);
        if (addr >= int'(DEPTH)) begin
            w = '0; known = 1;
        end else begin
            w = m_mem[addr]; known = m_memk[addr];
        end
    endfunction

    function automatic void m_step(input bit start, input int words, input bit flush,
                                   input bit valid, input logic [DATA_W-1:0] data);
        if (start) begin
            if (words >= 1 && words <= int'(DEPTH)) begin
                m_loading = 1; m_done = 0; m_err = 0;
                m_target = words; m_count = 0; m_lanes.delete();
            end else begin
                m_err = 1;
            end
        end else if (m_loading && flush) begin
            if (m_lanes.size() > 0) m_commit();
            m_loading = 0; m_done = 1;
        end else if (m_loading && valid) begin
            m_lanes.push_back(data);
            if (m_lanes.size() == int'(LANES)) begin
                m_commit();
                if (m_count == m_target) begin
                    m_loading = 0; m_done = 1;
                end
            end
        end else if (!m_loading && valid && !flush) begin
            m_err = 1;
        end
    endfunction

    // One clock with the currently driven inputs; checks comb and registered outputs.
    task automatic cycle();
        bit exp_ready;
        #1;
        exp_ready = m_loading && !bus.load_start && !bus.load_flush;
        check("wr_ready", WORD_W'(bus.wr_ready), WORD_W'(exp_ready));
        if (bus.rd_en) begin
            m_read(int'(bus.rd_addr1), e_rd1, e_rd1k);
            m_read(int'(bus.rd_addr2) + int'(bus.rd_offset), e_rd2, e_rd2k);
        end
        e_rdv = bus.rd_en;
        m_step(bus.load_start, int'(bus.load_words), bus.load_flush, bus.wr_valid, bus.wr_data);
        @(posedge clk);
        #1;
        check("load_done", WORD_W'(bus.load_done), WORD_W'(m_done));
        check("words_loaded", WORD_W'(bus.words_loaded), WORD_W'(m_count));
        check("err", WORD_W'(bus.err), WORD_W'(m_err));
        check("rd_valid", WORD_W'(bus.rd_valid), WORD_W'(e_rdv));
        if (e_rd1k) check("rd_data1", bus.rd_data1, e_rd1);
        if (e_rd2k) check("rd_data2", bus.rd_data2, e_rd2);
    endtask

    task automatic idle();
        bus.load_start = 0; bus.load_words = '0; bus.load_flush = 0;
        bus.wr_valid = 0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_addr1 = '0; bus.rd_addr2 = '0; bus.rd_offset = '0;
    endtask

    task automatic do_start(input int words);
        idle(); bus.load_start = 1; bus.load_words = (ADDR_W+1)'(words); cycle();
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        idle(); bus.wr_valid = 1; bus.wr_data = d; cycle();
    endtask

    task automatic do_flush();
        idle(); bus.load_flush = 1; cycle();
    endtask

    task automatic do_read(input int a1, input int a2, input int off);
        idle(); bus.rd_en = 1;
        bus.rd_addr1 = ADDR_W'(a1); bus.rd_addr2 = ADDR_W'(a2); bus.rd_offset = ADDR_W'(off);
        cycle();
    endtask

    localparam logic [WORD_W-1:0] K_WORD1 = 128'h0010_000f_000e_000d_000c_000b_000a_0009;
    localparam logic [WORD_W-1:0] K_FLUSH = 128'h0000_0000_0000_0000_0000_a00a_a009_a008;

    initial begin
        idle();
        rst = 1'b1;
        m_reset();
        foreach (m_memk[i]) m_memk[i] = 0;
        #12;
        check("rst_wr_ready", WORD_W'(bus.wr_ready), '0);
        check("rst_load_done", WORD_W'(bus.load_done), '0);
        check("rst_err", WORD_W'(bus.err), '0);
        check("rst_words", WORD_W'(bus.words_loaded), '0);
        check("rst_rd_valid", WORD_W'(bus.rd_valid), '0);
        check("rst_rd_data1", bus.rd_data1, '0);
        rst = 1'b0;
        cycle();

        // Two full words from a 1..16 ramp.
        do_start(2);
        for (int i = 1; i <= 16; i++) do_push(DATA_W'(i));
        check("tp1_done", WORD_W'(bus.load_done), WORD_W'(1));
        check("tp1_words", WORD_W'(bus.words_loaded), WORD_W'(2));
        do_read(1, 0, 1);
        check("tp2_rd1", bus.rd_data1, K_WORD1);
        check("tp2_rd2", bus.rd_data2, K_WORD1);
        check("tp2_valid", WORD_W'(bus.rd_valid), WORD_W'(1));
        cycle();

        // Partial final word committed by flush.
        do_start(4);
        for (int i = 0; i < 11; i++) do_push(DATA_W'(16'hA000 + i));
        do_flush();
        check("tp3_words", WORD_W'(bus.words_loaded), WORD_W'(2));
        check("tp3_done", WORD_W'(bus.load_done), WORD_W'(1));
        do_read(1, 1, 0);
        check("tp3_flush_word", bus.rd_data1, K_FLUSH);

        // Write outside a load flags err; the next good start clears it.
        do_push(16'h1234);
        check("tp4_err_set", WORD_W'(bus.err), WORD_W'(1));
        do_read(1, 0, 0);
        check("tp4_mem_kept", bus.rd_data1, K_FLUSH);
        do_start(1);
        check("tp4_err_clr", WORD_W'(bus.err), '0);

        // Fill the whole buffer, then read past the end on port 2.
        do_start(int'(DEPTH));
        for (int i = 0; i < int'(DEPTH * LANES); i++) do_push(DATA_W'($urandom));
        check("fill_done", WORD_W'(bus.load_done), WORD_W'(1));
        check("fill_words", WORD_W'(bus.words_loaded), WORD_W'(DEPTH));
        do_read(5, 60, 10);
        check("oob_rd2", bus.rd_data2, '0);

        // Asynchronous reset in the middle of a load.
        do_start(3);
        for (int i = 0; i < 3; i++) do_push(DATA_W'(16'h5550 + i));
        rst = 1'b1;
        #2;
        check("mid_rst_wr_ready", WORD_W'(bus.wr_ready), '0);
        check("mid_rst_words", WORD_W'(bus.words_loaded), '0);
        check("mid_rst_done", WORD_W'(bus.load_done), '0);
        m_reset();
        rst = 1'b0;
        do_start(0);
        check("zero_len_err", WORD_W'(bus.err), WORD_W'(1));
        do_push(16'h7777);
        do_start(70);
        check("long_len_err", WORD_W'(bus.err), WORD_W'(1));

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            int r;
            idle();
            r = $urandom_range(0, 99);
            if (r < 3) begin
                bus.load_start = 1;
                bus.load_words = (ADDR_W+1)'($urandom_range(0, 70));
            end else if (r < 6) begin
                bus.load_flush = 1;
            end
            bus.wr_valid  = ($urandom_range(0, 99) < 75);
            bus.wr_data   = DATA_W'($urandom);
            bus.rd_en     = 1'($urandom_range(0, 1));
            bus.rd_addr1  = ADDR_W'($urandom);
            bus.rd_addr2  = ADDR_W'($urandom);
            bus.rd_offset = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : '0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
